// File: rtl/video_fx_pkg.sv
// video_fx_pkg: shared mode/direction types and FVHT bit positions for the video effect path
package video_fx_pkg;
    typedef enum logic [1:0] {MODE_PASS, MODE_INVERT, MODE_BLACK, MODE_WHITE} mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    localparam int FVHT_V = 2;
    localparam int FVHT_H = 1;
endpackage

// File: rtl/bar_sweep_ctrl.sv
// bar_sweep_ctrl: per-frame ping-pong sweep of the bar start offset
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_v            : V blank flag
//   o_frame_evt    : one-cycle pulse on each V rising edge
//   o_offset       : current bar start offset, clamped to [0, MAX_OFFSET]
module bar_sweep_ctrl
    import video_fx_pkg::*;
#(
    parameter int OFS_W      = 13,
    parameter int MAX_OFFSET = 3800,
    parameter int STEP       = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_v,
    output logic             o_frame_evt,
    output logic [OFS_W-1:0] o_offset
);
    localparam logic [OFS_W:0]   MAX_EXT  = (OFS_W+1)'(MAX_OFFSET);
    localparam logic [OFS_W:0]   STEP_EXT = (OFS_W+1)'(STEP);
    localparam logic [OFS_W-1:0] STEP_W   = OFS_W'(STEP);
    logic           v_q;
    dir_e           dir;
    logic [OFS_W:0] up_sum;
    assign o_frame_evt = i_v & ~v_q;
    // one extra bit so the upper clamp test cannot wrap
    assign up_sum = {1'b0, o_offset} + STEP_EXT;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q      <= 1'b0;
            dir      <= DIR_UP;
            o_offset <= '0;
        end else begin
            v_q <= i_v;
            if (o_frame_evt) begin
                if (dir == DIR_UP) begin
                    if (up_sum >= MAX_EXT) begin
                        o_offset <= MAX_EXT[OFS_W-1:0];
                        dir      <= DIR_DOWN;
                    end else begin
                        o_offset <= up_sum[OFS_W-1:0];
                    end
                end else begin
                    if ({1'b0, o_offset} <= STEP_EXT) begin
                        o_offset <= '0;
                        dir      <= DIR_UP;
                    end else begin
                        o_offset <= o_offset - STEP_W;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/sweep_bar_modifier.sv
// sweep_bar_modifier: applies a selectable effect to a sweeping bar window on a 2-channel video word
//   i_clk, i_rst      : pixel clock, synchronous active-high reset
//   i_vdat_colour     : video word, ch0=[CW-1:0], ch1=[2*CW-1:CW]
//   i_fvht            : flags, [2]=V blank, [1]=H blank
//   i_enable/i_mode/i_ch_mask : effect config, taken into effect on the next V rising edge
//   o_updated_colour  : processed video word, 1 cycle latency
//   o_fvht            : i_fvht aligned with o_updated_colour
module sweep_bar_modifier
    import video_fx_pkg::*;
#(
    parameter int          CW         = 10,
    parameter int          OFS_W      = 13,
    parameter int          BAR_WIDTH  = 256,
    parameter int          MAX_OFFSET = 3800,
    parameter int          STEP       = 1,
    parameter logic [CW-1:0] BLACK_VAL = 10'h040,
    parameter logic [CW-1:0] WHITE_VAL = 10'h3AC
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2*CW-1:0] i_vdat_colour,
    input  logic [3:0]      i_fvht,
    input  logic            i_enable,
    input  logic [1:0]      i_mode,
    input  logic [1:0]      i_ch_mask,
    output logic [2*CW-1:0] o_updated_colour,
    output logic [3:0]      o_fvht
);
    logic [OFS_W-1:0] pix_cnt;
    logic [OFS_W-1:0] offset;
    logic             frame_evt;
    mode_e            sh_mode;
    logic [1:0]       sh_mask;
    logic             sh_en;
    logic             blank;
    logic             in_bar;
    logic [OFS_W:0]   bar_end;
    logic [2*CW-1:0]  fx_colour;

    bar_sweep_ctrl #(
        .OFS_W      (OFS_W),
        .MAX_OFFSET (MAX_OFFSET),
        .STEP       (STEP)
    ) u_sweep (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_v         (i_fvht[FVHT_V]),
        .o_frame_evt (frame_evt),
        .o_offset    (offset)
    );

    assign blank   = i_fvht[FVHT_H] | i_fvht[FVHT_V];
    // exclusive end computed one bit wider so a window near the top of the range never wraps
    assign bar_end = {1'b0, offset} + (OFS_W+1)'(BAR_WIDTH);
    assign in_bar  = ~blank & (pix_cnt >= offset) & ({1'b0, pix_cnt} < bar_end);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [CW-1:0] d;
        assign d = i_vdat_colour[c*CW +: CW];
        assign fx_colour[c*CW +: CW] = (sh_en & sh_mask[c] & in_bar) ?
            (sh_mode == MODE_INVERT ? ~d :
             sh_mode == MODE_BLACK  ? BLACK_VAL :
             sh_mode == MODE_WHITE  ? WHITE_VAL : d) : d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_cnt          <= '0;
            sh_mode          <= MODE_PASS;
            sh_mask          <= '0;
            sh_en            <= 1'b0;
            o_updated_colour <= '0;
            o_fvht           <= '0;
        end else begin
            pix_cnt <= i_fvht[FVHT_H] ? '0 : (&pix_cnt ? pix_cnt : pix_cnt + OFS_W'(1));
            if (frame_evt) begin
                sh_mode <= mode_e'(i_mode);
                sh_mask <= i_ch_mask;
                sh_en   <= i_enable;
            end
            o_updated_colour <= fx_colour;
            o_fvht           <= i_fvht;
        end
    end
endmodule

// File: tb/tb_sweep_bar_modifier.sv
// tb_sweep_bar_modifier: directed + random check of sweep_bar_modifier against a frame-level model
module tb_sweep_bar_modifier;
    localparam int CW = 10, OFS_W = 13, BW = 4, MAXO = 8, STEP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [19:0]   vdat = '0;
    logic [3:0]    fvht = '0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [1:0]    mask = 2'd0;
    logic [19:0]   o_col;
    logic [3:0]    o_fvht;

    int n_cmp = 0, n_bad = 0;
    int m_off = 0, pix = 0;
    bit m_up = 1, m_vprev = 0, m_en = 0;
    logic [1:0] m_mode = 0, m_mask = 0;

    sweep_bar_modifier #(
        .CW(CW), .OFS_W(OFS_W), .BAR_WIDTH(BW), .MAX_OFFSET(MAXO), .STEP(STEP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_vdat_colour(vdat), .i_fvht(fvht),
        .i_enable(en), .i_mode(mode), .i_ch_mask(mask),
        .o_updated_colour(o_col), .o_fvht(o_fvht)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] expect_word(input logic [19:0] d, input bit bar);
        logic [19:0] r;
        r = d;
        for (int ch = 0; ch < 2; ch++) begin
            if (bar && m_en && m_mask[ch]) begin
                case (m_mode)
                    2'd1: r[ch*CW +: CW] = ~d[ch*CW +: CW];
                    2'd2: r[ch*CW +: CW] = 10'h040;
                    2'd3: r[ch*CW +: CW] = 10'h3AC;
                    default: r[ch*CW +: CW] = d[ch*CW +: CW];
                endcase
            end
        end
        return r;
    endfunction

    task automatic step(input logic [19:0] d, input logic [3:0] f, input string tag);
        logic [19:0] exp;
        bit bar;
        vdat = d;
        fvht = f;
        bar = !(f[1] || f[2]) && pix >= m_off && pix < m_off + BW;
        exp = expect_word(d, bar);
        tick();
        n_cmp++;
        assert (o_col === exp) else begin
            n_bad++;
            $error("FAIL %s data pix=%0d off=%0d: got %h expected %h", tag, pix, m_off, o_col, exp);
        end
        n_cmp++;
        assert (o_fvht === f) else begin
            n_bad++;
            $error("FAIL %s fvht: got %h expected %h", tag, o_fvht, f);
        end
        if (f[2] && !m_vprev) begin
            if (m_up) begin
                if (m_off + STEP >= MAXO) begin m_off = MAXO; m_up = 0; end
                else m_off = m_off + STEP;
            end else begin
                if (m_off <= STEP) begin m_off = 0; m_up = 1; end
                else m_off = m_off - STEP;
            end
            m_mode = mode;
            m_mask = mask;
            m_en = en;
        end
        m_vprev = f[2];
        pix = f[1] ? 0 : (pix < (1 << OFS_W) - 1 ? pix + 1 : pix);
    endtask

    function automatic logic [19:0] rnd();
        return 20'($urandom());
    endfunction

    task automatic frame(input int hold);
        for (int i = 0; i <= hold; i++) step(rnd(), 4'b0110, "vblank");
        step(rnd(), 4'b0010, "hblank");
    endtask

    task automatic line(input bit fixed, input string tag);
        for (int i = 0; i < 12; i++) step(fixed ? {10'h200, 10'h100} : rnd(), 4'b0000, tag);
        step(rnd(), 4'b0010, "hblank");
    endtask

    task automatic do_reset();
        rst = 1;
        vdat = rnd();
        fvht = 4'b0110;
        tick();
        n_cmp++;
        assert (o_col === 20'h0) else begin
            n_bad++;
            $error("FAIL reset data: got %h expected %h", o_col, 20'h0);
        end
        n_cmp++;
        assert (o_fvht === 4'h0) else begin
            n_bad++;
            $error("FAIL reset fvht: got %h expected %h", o_fvht, 4'h0);
        end
        m_off = 0; m_up = 1; m_vprev = 0; m_en = 0; m_mode = 0; m_mask = 0; pix = 0;
        rst = 0;
    endtask

    initial begin
        do_reset();
        mode = 2'd1; mask = 2'b01; en = 1;
        line(1, "pass_before_evt");
        frame(0);
        line(1, "invert_first");
        for (int k = 0; k < 8; k++) begin
            frame(0);
            line(1, "sweep_fixed");
            line(0, "sweep_rand");
        end
        frame(100);
        line(1, "vhold");
        mode = 2'd3;
        line(1, "white_pending");
        frame(0);
        line(1, "white");
        mode = 2'd2; mask = 2'b11;
        frame(0);
        line(0, "black");
        for (int i = 0; i < 12; i++) step(rnd(), 4'b0010, "hblank_window");
        for (int i = 0; i < 6; i++) step(rnd(), 4'b0100, "vblank_level");
        step(rnd(), 4'b0010, "hblank");
        mode = 2'd1; mask = 2'b10; en = 1;
        for (int k = 0; k < 20 && m_off != 6; k++) begin
            frame(0);
            line(0, "seek");
        end
        n_cmp++;
        assert (m_off == 6) else begin
            n_bad++;
            $error("FAIL seek_offset: got %0d expected %0d", m_off, 6);
        end
        for (int i = 0; i < 5; i++) step(rnd(), 4'b0000, "pre_reset");
        do_reset();
        line(0, "after_reset_pass");
        frame(0);
        line(1, "after_reset_fixed");
        line(0, "after_reset_rand");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
